// File: rtl/pin_input_sync.sv
// Pad input conditioning: multi-stage synchronizer, per-pin stability filter,
// output-value merge for pins driven locally, and registered rise/fall pulses.
module pin_input_sync #(
    parameter int unsigned      WIDTH         = 32,
    parameter int unsigned      SYNC_STAGES   = 2,
    parameter int unsigned      FILTER_CYCLES = 4,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic             pllX16,
    input  logic             res,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] pin_dir,
    input  logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_sync,
    output logic [WIDTH-1:0] pin_rise,
    output logic [WIDTH-1:0] pin_fall
);

    localparam int unsigned    CntW    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_s;
    logic [WIDTH-1:0] filt_q, filt_d;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    always_ff @(posedge pllX16 or posedge res) begin
        if (res) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT;
            end
        end else begin
            sync_q[0] <= pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // A new level is accepted only after FILTER_CYCLES consecutive disagreeing cycles.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != filt_q[i]) begin
                if (cnt_q[i] == CntLast) begin
                    filt_d[i] = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge pllX16 or posedge res) begin
        if (res) begin
            filt_q <= INIT;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Locally driven pins bypass the synchronizer so cogs see their own outputs at once.
    assign pin_sync = (pin_dir & pin_out) | (~pin_dir & filt_q);

    always_comb begin
        rise_d = pin_sync & ~hist_q;
        fall_d = ~pin_sync & hist_q;
    end

    always_ff @(posedge pllX16 or posedge res) begin
        if (res) begin
            hist_q <= INIT;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            hist_q <= pin_sync;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign pin_rise = rise_q;
    assign pin_fall = fall_q;

endmodule

// File: tb/tb_pin_input_sync.sv
// Directed bench for pin_input_sync: expected outputs are queued with a target cycle
// when stimulus is applied and compared when that cycle is reached.
module tb_pin_input_sync;

    logic        clk = 1'b0;
    logic        res;
    logic [31:0] pin_in, pin_dir, pin_out;
    logic [31:0] sync0, rise0, fall0;
    logic [31:0] sync1, rise1, fall1;

    always #5 clk = ~clk;

    pin_input_sync dut0 (
        .pllX16  (clk),
        .res     (res),
        .pin_in  (pin_in),
        .pin_dir (pin_dir),
        .pin_out (pin_out),
        .pin_sync(sync0),
        .pin_rise(rise0),
        .pin_fall(fall0)
    );

    pin_input_sync #(.INIT(32'hFFFF_FFFF)) dut1 (
        .pllX16  (clk),
        .res     (res),
        .pin_in  (32'h0),
        .pin_dir (32'h0),
        .pin_out (32'h0),
        .pin_sync(sync1),
        .pin_rise(rise1),
        .pin_fall(fall1)
    );

    typedef struct {
        int          cyc;
        bit          sel;
        string       tag;
        logic [31:0] sy;
        logic [31:0] ri;
        logic [31:0] fa;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    endtask

    task automatic expect_at(input int d, input bit sel, input string tag,
                             input logic [31:0] sy, input logic [31:0] ri,
                             input logic [31:0] fa);
        exp_t e;
        e.cyc = cyc + d;
        e.sel = sel;
        e.tag = tag;
        e.sy  = sy;
        e.ri  = ri;
        e.fa  = fa;
        sb.push_back(e);
    endtask

    task automatic check_due();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                cmp({sb[i].tag, ".sync"}, sb[i].sel ? sync1 : sync0, sb[i].sy);
                cmp({sb[i].tag, ".rise"}, sb[i].sel ? rise1 : rise0, sb[i].ri);
                cmp({sb[i].tag, ".fall"}, sb[i].sel ? fall1 : fall0, sb[i].fa);
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic peek();
        #1;
        check_due();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        res     = 1'b1;
        pin_in  = '0;
        pin_dir = '0;
        pin_out = '0;
        expect_at(2, 1'b0, "rst0", 32'h0, 32'h0, 32'h0);
        expect_at(2, 1'b1, "rst1", 32'hFFFF_FFFF, 32'h0, 32'h0);
        idle(2);

        // Release reset with pin 5 stepped high; INIT-ones instance decays to zero.
        res       = 1'b0;
        pin_in[5] = 1'b1;
        expect_at(5, 1'b0, "t1.pre",  32'h0,       32'h0,       32'h0);
        expect_at(6, 1'b0, "t1.sync", 32'h20,      32'h0,       32'h0);
        expect_at(7, 1'b0, "t1.rise", 32'h20,      32'h20,      32'h0);
        expect_at(8, 1'b0, "t1.done", 32'h20,      32'h0,       32'h0);
        expect_at(5, 1'b1, "t6.pre",  32'hFFFF_FFFF, 32'h0,     32'h0);
        expect_at(6, 1'b1, "t6.drop", 32'h0,       32'h0,       32'h0);
        expect_at(7, 1'b1, "t6.fall", 32'h0,       32'h0,       32'hFFFF_FFFF);
        expect_at(8, 1'b1, "t6.done", 32'h0,       32'h0,       32'h0);
        idle(8);
        pin_in[5] = 1'b0;
        idle(12);

        // 3-cycle glitch is rejected.
        pin_in[9] = 1'b1;
        expect_at(6, 1'b0, "t2a.c6", 32'h0, 32'h0, 32'h0);
        expect_at(7, 1'b0, "t2a.c7", 32'h0, 32'h0, 32'h0);
        expect_at(8, 1'b0, "t2a.c8", 32'h0, 32'h0, 32'h0);
        idle(3);
        pin_in[9] = 1'b0;
        idle(10);

        // 4-cycle pulse is passed through as a 4-cycle pulse.
        pin_in[9] = 1'b1;
        expect_at(5,  1'b0, "t2b.pre",  32'h0,   32'h0,   32'h0);
        expect_at(6,  1'b0, "t2b.up",   32'h200, 32'h0,   32'h0);
        expect_at(7,  1'b0, "t2b.rise", 32'h200, 32'h200, 32'h0);
        expect_at(9,  1'b0, "t2b.hold", 32'h200, 32'h0,   32'h0);
        expect_at(10, 1'b0, "t2b.down", 32'h0,   32'h0,   32'h0);
        expect_at(11, 1'b0, "t2b.fall", 32'h0,   32'h0,   32'h200);
        expect_at(12, 1'b0, "t2b.done", 32'h0,   32'h0,   32'h0);
        idle(4);
        pin_in[9] = 1'b0;
        idle(10);

        // Output pin toggled for one cycle: zero-latency merge, rise then fall.
        pin_dir[0] = 1'b1;
        step();
        pin_out[0] = 1'b1;
        expect_at(0, 1'b0, "t3.now1", 32'h1, 32'h0, 32'h0);
        peek();
        expect_at(1, 1'b0, "t3.rise", 32'h1, 32'h1, 32'h0);
        step();
        pin_out[0] = 1'b0;
        expect_at(0, 1'b0, "t3.now0", 32'h0, 32'h1, 32'h0);
        peek();
        expect_at(1, 1'b0, "t3.fall", 32'h0, 32'h0, 32'h1);
        expect_at(2, 1'b0, "t3.done", 32'h0, 32'h0, 32'h0);
        idle(2);
        pin_dir[0] = 1'b0;

        // Filter tracks the pad while pin 31 is an output; exposed at once on turnaround.
        pin_dir[31] = 1'b1;
        pin_in[31]  = 1'b1;
        expect_at(20, 1'b0, "t4.out", 32'h0, 32'h0, 32'h0);
        idle(20);
        pin_dir[31] = 1'b0;
        expect_at(0, 1'b0, "t4.now", 32'h8000_0000, 32'h0, 32'h0);
        peek();
        expect_at(1, 1'b0, "t4.rise", 32'h8000_0000, 32'h8000_0000, 32'h0);
        expect_at(2, 1'b0, "t4.done", 32'h8000_0000, 32'h0, 32'h0);
        idle(2);
        pin_in[31] = 1'b0;
        idle(12);

        // Reset mid-qualification of pin 3 while a pulse on pin 1 is live.
        pin_in[3] = 1'b1;
        idle(4);
        pin_dir[1] = 1'b1;
        pin_out[1] = 1'b1;
        expect_at(1, 1'b0, "t5.live", 32'h2, 32'h2, 32'h0);
        step();
        res = 1'b1;
        expect_at(0, 1'b0, "t5.rst", 32'h2, 32'h0, 32'h0);
        peek();
        pin_dir[1] = 1'b0;
        pin_out[1] = 1'b0;
        expect_at(1, 1'b0, "t5.held", 32'h0, 32'h0, 32'h0);
        step();
        res = 1'b0;
        expect_at(5, 1'b0, "t5.pre",  32'h0, 32'h0, 32'h0);
        expect_at(6, 1'b0, "t5.sync", 32'h8, 32'h0, 32'h0);
        expect_at(7, 1'b0, "t5.rise", 32'h8, 32'h8, 32'h0);
        idle(8);

        for (int i = 0; i < sb.size(); i++) begin
            cmp({sb[i].tag, ".unchecked"}, 32'h0, 32'h1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
